// File: rtl/spmm_lhs_encoder.sv
// spmm_lhs_encoder
// Front-end compressor for the SpMM sparse LHS port. Dense rows arrive one
// per handshake, their nonzeros are packed in row-major order into a staging
// buffer, and the frame is then replayed as N-wide chunks of (column, value)
// pairs alongside a per-row cumulative pointer vector.
//
// Optional build macro: SPMM_ENC_PINGPONG_EN
//   Defined   -> two staging banks used alternately, so a new frame can be
//                collected while the previous one is still being emitted.
//   Undefined -> single bank; row intake stalls for the whole emission.
module spmm_lhs_encoder #(
   parameter int N     = 16,
   parameter int W     = 8,
   parameter int lgN   = $clog2(N),
   parameter int dbLgN = 2 * $clog2(N)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        row_valid,
   output logic                        row_ready,
   input  logic [N-1:0][W-1:0]         row_data,
   output logic                        lhs_valid,
   input  logic                        lhs_ready,
   output logic                        lhs_start,
   output logic                        lhs_last,
   output logic [N-1:0][dbLgN-1:0]     lhs_ptr,
   output logic [N-1:0][lgN-1:0]       lhs_col,
   output logic [N-1:0][W-1:0]         lhs_data,
   output logic [dbLgN:0]              nnz_total,
   output logic                        ptr_wrap
);

   localparam int DEPTH = N * N;

`ifdef SPMM_ENC_PINGPONG_EN
   localparam logic PINGPONG = 1'b1;
`else
   localparam logic PINGPONG = 1'b0;
`endif

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } encState_t;

   encState_t stateQ, stateD;

   logic aliveQ;

   logic [lgN-1:0] rowCntQ, rowCntD;
   logic [lgN-1:0] chunkQ, chunkD;
   logic           colBankQ, colBankD;
   logic           emitBankQ, emitBankD;
   logic [1:0]     bankFullQ, bankFullD;

   logic [1:0][dbLgN:0]                nnzQ, nnzD;
   logic [1:0][N-1:0][dbLgN-1:0]       ptrQ, ptrD;

   logic [W-1:0]   stageData [2][DEPTH];
   logic [lgN-1:0] stageCol  [2][DEPTH];

   logic [W-1:0]     packVal [N];
   logic [lgN-1:0]   packCol [N];
   logic [lgN:0]     rowCount;
   logic [dbLgN-1:0] wrIdx [N];
   logic             wrEn  [N];
   logic [dbLgN-1:0] rdIdx [N];
   logic [dbLgN:0]   runSum;
   logic [dbLgN:0]   nnzEmit;
   logic [lgN-1:0]   lastChunkIdx;

   logic rowAccept;
   logic lastRow;
   logic chunkAccept;
   logic frameDone;

   // Handshake qualifiers and the registered view of the bank being emitted.
   // Everything on the chunk side is derived from registered state only, so
   // lhs_ready never reaches the lhs_* outputs combinationally.
   always_comb begin
      nnzEmit      = nnzQ[emitBankQ];
      lastChunkIdx = '0;
      if (nnzEmit != '0) begin
         lastChunkIdx = lgN'((nnzEmit - (dbLgN+1)'(1)) >> lgN);
      end
      row_ready   = aliveQ && !bankFullQ[colBankQ];
      rowAccept   = row_valid && row_ready;
      lastRow     = rowAccept && (rowCntQ == lgN'(N-1));
      chunkAccept = (stateQ == EMIT) && lhs_ready;
      frameDone   = chunkAccept && (chunkQ == lastChunkIdx);
   end

   // Squeeze the incoming row: each nonzero lands at the slot equal to the
   // number of nonzeros to its left, which keeps columns in ascending order.
   always_comb begin
      rowCount = '0;
      for (int i = 0; i < N; i++) begin
         packVal[i] = '0;
         packCol[i] = '0;
      end
      for (int c = 0; c < N; c++) begin
         if (row_data[c] != '0) begin
            packVal[rowCount[lgN-1:0]] = row_data[c];
            packCol[rowCount[lgN-1:0]] = lgN'(c);
            rowCount = rowCount + (lgN+1)'(1);
         end
      end
   end

   // Staging addresses: packed slot i of this row goes right after the
   // nonzeros already collected for the frame. The running count never
   // exceeds N*N, so the low dbLgN bits address the buffer exactly.
   always_comb begin
      runSum = nnzQ[colBankQ] + {{(dbLgN-lgN){1'b0}}, rowCount};
      for (int i = 0; i < N; i++) begin
         wrIdx[i] = dbLgN'(nnzQ[colBankQ] + (dbLgN+1)'(i));
         wrEn[i]  = rowAccept && ((lgN+1)'(i) < rowCount);
      end
   end

   // Staging buffer write port: the whole packed row is stored on the same
   // edge that accepts it, so intake runs at one row per cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int e = 0; e < DEPTH; e++) begin
               stageData[b][e] <= '0;
               stageCol[b][e]  <= '0;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (wrEn[i]) begin
               stageData[colBankQ][wrIdx[i]] <= packVal[i];
               stageCol[colBankQ][wrIdx[i]]  <= packCol[i];
            end
         end
      end
   end

   // Chunk read port: chunk j shows staging entries jN..jN+N-1; slots past
   // the frame's nonzero count read as zero so the tail chunk is padded.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         rdIdx[i]    = {chunkQ, lgN'(i)};
         lhs_data[i] = '0;
         lhs_col[i]  = '0;
         if ((stateQ == EMIT) && ({1'b0, rdIdx[i]} < nnzEmit)) begin
            lhs_data[i] = stageData[emitBankQ][rdIdx[i]];
            lhs_col[i]  = stageCol[emitBankQ][rdIdx[i]];
         end
      end
   end

   // Next-state logic: intake bookkeeping for the collecting bank, chunk
   // stepping and end-of-frame cleanup for the emitting bank. The two banks
   // are never the same while both are active, so the updates never collide.
   always_comb begin
      stateD    = stateQ;
      rowCntD   = rowCntQ;
      chunkD    = chunkQ;
      colBankD  = colBankQ;
      emitBankD = emitBankQ;
      bankFullD = bankFullQ;
      nnzD      = nnzQ;
      ptrD      = ptrQ;

      if (rowAccept) begin
         nnzD[colBankQ]          = runSum;
         ptrD[colBankQ][rowCntQ] = runSum[dbLgN-1:0];
         rowCntD                 = rowCntQ + lgN'(1);
         if (lastRow) begin
            bankFullD[colBankQ] = 1'b1;
            colBankD            = colBankQ ^ PINGPONG;
         end
      end

      if (frameDone) begin
         bankFullD[emitBankQ] = 1'b0;
         nnzD[emitBankQ]      = '0;
         ptrD[emitBankQ]      = '0;
         chunkD               = '0;
         emitBankD            = emitBankQ ^ PINGPONG;
      end else if (chunkAccept) begin
         chunkD = chunkQ + lgN'(1);
      end

      case (stateQ)
         COLLECT: begin
            if (lastRow) begin
               stateD = EMIT;
            end
         end
         EMIT: begin
            if (frameDone) begin
               stateD = bankFullD[emitBankD] ? EMIT : COLLECT;
            end
         end
         default: begin
            stateD = COLLECT;
         end
      endcase
   end

   // State and bookkeeping registers. aliveQ holds row_ready low until the
   // first clock edge after reset is released.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stateQ    <= COLLECT;
         aliveQ    <= 1'b0;
         rowCntQ   <= '0;
         chunkQ    <= '0;
         colBankQ  <= 1'b0;
         emitBankQ <= 1'b0;
         bankFullQ <= '0;
         nnzQ      <= '0;
         ptrQ      <= '0;
      end else begin
         stateQ    <= stateD;
         aliveQ    <= 1'b1;
         rowCntQ   <= rowCntD;
         chunkQ    <= chunkD;
         colBankQ  <= colBankD;
         emitBankQ <= emitBankD;
         bankFullQ <= bankFullD;
         nnzQ      <= nnzD;
         ptrQ      <= ptrD;
      end
   end

   // Chunk framing and frame-level metadata, all from registered state.
   always_comb begin
      lhs_valid = (stateQ == EMIT);
      lhs_start = (stateQ == EMIT) && (chunkQ == '0);
      lhs_last  = (stateQ == EMIT) && (chunkQ == lastChunkIdx);
      lhs_ptr   = ptrQ[emitBankQ];
      nnz_total = nnzEmit;
      ptr_wrap  = (nnzEmit == (dbLgN+1)'(DEPTH));
   end

endmodule

// File: tb/tb_spmm_lhs_encoder.sv
// Testbench for spmm_lhs_encoder (default single-bank build). A frame-level
// model rebuilds the expected CSR stream from the rows the bench hands over
// and is compared against the DUT every cycle; directed frames pin the model
// with hand-computed values.
module tb_spmm_lhs_encoder;

   localparam int N     = 16;
   localparam int W     = 8;
   localparam int LGN   = 4;
   localparam int DBLGN = 8;

   logic                     clock = 1'b0;
   logic                     reset = 1'b1;
   logic                     row_valid = 1'b0;
   logic                     row_ready;
   logic [N-1:0][W-1:0]      row_data = '0;
   logic                     lhs_valid;
   logic                     lhs_ready = 1'b0;
   logic                     lhs_start;
   logic                     lhs_last;
   logic [N-1:0][DBLGN-1:0]  lhs_ptr;
   logic [N-1:0][LGN-1:0]    lhs_col;
   logic [N-1:0][W-1:0]      lhs_data;
   logic [DBLGN:0]           nnz_total;
   logic                     ptr_wrap;

   int checks = 0;
   int errors = 0;

   logic [N-1:0][W-1:0] stimMat [N];

   logic [N-1:0][W-1:0] mdlMat [N];
   int  mdlRows = 0;
   bit  mdlEmit = 1'b0;
   int  mdlChunk = 0;
   int  expVal[$];
   int  expCol[$];
   int  expPtr [N];
   int  expNnz = 0;
   int  expChunks = 1;
   bit  tbAlive = 1'b0;

   always #5 clock = ~clock;

   spmm_lhs_encoder dut (
      .clock     (clock),
      .reset     (reset),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_data  (row_data),
      .lhs_valid (lhs_valid),
      .lhs_ready (lhs_ready),
      .lhs_start (lhs_start),
      .lhs_last  (lhs_last),
      .lhs_ptr   (lhs_ptr),
      .lhs_col   (lhs_col),
      .lhs_data  (lhs_data),
      .nnz_total (nnz_total),
      .ptr_wrap  (ptr_wrap)
   );

   // One comparison: count it, and report it when the values disagree.
   task automatic checkOutput(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Flatten the collected matrix into the row-major nonzero list and the
   // cumulative per-row counts the encoder is expected to publish.
   function automatic void buildModel();
      expVal.delete();
      expCol.delete();
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (mdlMat[r][c] != '0) begin
               expVal.push_back(int'(mdlMat[r][c]));
               expCol.push_back(c);
            end
         end
         expPtr[r] = expVal.size() % 256;
      end
      expNnz    = expVal.size();
      expChunks = (expNnz == 0) ? 1 : (expNnz + N - 1) / N;
   endfunction

   // row_ready may only rise on a clock edge that sees reset released.
   always @(posedge clock or posedge reset) begin
      if (reset) tbAlive <= 1'b0;
      else       tbAlive <= 1'b1;
   end

   // Per-cycle compare against the frame model, sampled mid-cycle; the model
   // then advances by whatever handshake will complete on the next edge.
   always @(negedge clock) begin
      logic [N-1:0][W-1:0]     eData;
      logic [N-1:0][LGN-1:0]   eCol;
      logic [N-1:0][DBLGN-1:0] ePtr;
      if (reset) begin
         mdlRows  = 0;
         mdlEmit  = 1'b0;
         mdlChunk = 0;
         checkOutput("reset row_ready", 256'(row_ready), 256'(0));
         checkOutput("reset lhs_valid", 256'(lhs_valid), 256'(0));
         checkOutput("reset lhs_data", 256'(lhs_data), 256'(0));
         checkOutput("reset lhs_ptr", 256'(lhs_ptr), 256'(0));
         checkOutput("reset nnz_total", 256'(nnz_total), 256'(0));
      end else begin
         checkOutput("row_ready", 256'(row_ready), 256'(tbAlive && !mdlEmit));
         checkOutput("lhs_valid", 256'(lhs_valid), 256'(mdlEmit));
         if (mdlEmit) begin
            for (int i = 0; i < N; i++) begin
               int idx;
               idx = mdlChunk * N + i;
               eData[i] = (idx < expNnz) ? W'(expVal[idx]) : '0;
               eCol[i]  = (idx < expNnz) ? LGN'(expCol[idx]) : '0;
               ePtr[i]  = DBLGN'(expPtr[i]);
            end
            checkOutput("lhs_data", 256'(lhs_data), 256'(eData));
            checkOutput("lhs_col", 256'(lhs_col), 256'(eCol));
            checkOutput("lhs_ptr", 256'(lhs_ptr), 256'(ePtr));
            checkOutput("lhs_start", 256'(lhs_start), 256'(mdlChunk == 0));
            checkOutput("lhs_last", 256'(lhs_last), 256'(mdlChunk == expChunks - 1));
            checkOutput("nnz_total", 256'(nnz_total), 256'(expNnz));
            checkOutput("ptr_wrap", 256'(ptr_wrap), 256'(expNnz == N * N));
            if (lhs_ready) begin
               if (mdlChunk == expChunks - 1) begin
                  mdlEmit = 1'b0;
                  mdlRows = 0;
               end else begin
                  mdlChunk++;
               end
            end
         end else if (row_valid && tbAlive) begin
            mdlMat[mdlRows] = row_data;
            mdlRows++;
            if (mdlRows == N) begin
               buildModel();
               mdlEmit  = 1'b1;
               mdlChunk = 0;
            end
         end
      end
   end

   // Feed the 16 rows of stimMat with random idle gaps between them.
   task automatic applyStimulus(input int gapPct);
      bit accepted;
      for (int r = 0; r < N; r++) begin
         while (int'($urandom_range(99)) < gapPct) begin
            row_valid = 1'b0;
            for (int c = 0; c < N; c++) row_data[c] = W'($urandom_range(255));
            @(posedge clock);
            #1;
         end
         row_valid = 1'b1;
         row_data  = stimMat[r];
         accepted  = 1'b0;
         for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge clock);
            accepted = row_ready;
            @(posedge clock);
            #1;
         end
         checkOutput("row accept timeout", 256'(accepted), 256'(1));
      end
      row_valid = 1'b0;
   endtask

   // Drain the current frame with random readiness, an optional forced stall
   // on one chunk, and optional junk rows offered while the frame drains.
   task automatic drainFrame(input int readyPct, input int holdChunk,
                             input int holdCycles, input bit junkRows);
      bit done;
      int accepted;
      int holdLeft;
      done     = 1'b0;
      accepted = 0;
      holdLeft = holdCycles;
      for (int t = 0; t < 400 && !done; t++) begin
         lhs_ready = (int'($urandom_range(99)) < readyPct);
         if (accepted == holdChunk && holdLeft > 0) begin
            lhs_ready = 1'b0;
            holdLeft--;
         end
         row_valid = junkRows ? 1'($urandom_range(1)) : 1'b0;
         for (int c = 0; c < N; c++) row_data[c] = W'($urandom_range(255));
         @(negedge clock);
         if (lhs_valid && lhs_ready) begin
            accepted++;
            if (lhs_last) done = 1'b1;
         end
         @(posedge clock);
         #1;
      end
      row_valid = 1'b0;
      lhs_ready = 1'b0;
      checkOutput("frame drain timeout", 256'(done), 256'(1));
   endtask

   task automatic randomMatrix(input int densityPct);
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            stimMat[r][c] = (int'($urandom_range(99)) < densityPct) ?
                            W'($urandom_range(255)) : '0;
         end
      end
   endtask

   // Directed frames with literal expectations, then reset and random frames.
   initial begin
      #2;
      checkOutput("por row_ready", 256'(row_ready), 256'(0));
      checkOutput("por lhs_valid", 256'(lhs_valid), 256'(0));
      checkOutput("por lhs_ptr", 256'(lhs_ptr), 256'(0));
      checkOutput("por ptr_wrap", 256'(ptr_wrap), 256'(0));
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("release row_ready", 256'(row_ready), 256'(0));
      @(posedge clock);
      #1;
      checkOutput("first edge row_ready", 256'(row_ready), 256'(1));

      // Diagonal: row r holds r+1 at column r.
      for (int r = 0; r < N; r++) begin
         stimMat[r] = '0;
         stimMat[r][r] = W'(r + 1);
      end
      applyStimulus(0);
      lhs_ready = 1'b0;
      @(negedge clock);
      checkOutput("diag data3", 256'(lhs_data[3]), 256'(4));
      checkOutput("diag col15", 256'(lhs_col[15]), 256'(15));
      checkOutput("diag ptr0", 256'(lhs_ptr[0]), 256'(1));
      checkOutput("diag ptr15", 256'(lhs_ptr[15]), 256'(16));
      checkOutput("diag nnz", 256'(nnz_total), 256'(16));
      checkOutput("diag start", 256'(lhs_start), 256'(1));
      checkOutput("diag last", 256'(lhs_last), 256'(1));
      @(posedge clock);
      #1;
      drainFrame(100, -1, 0, 1'b0);

      // All-zero matrix: one padded chunk.
      for (int r = 0; r < N; r++) stimMat[r] = '0;
      applyStimulus(20);
      @(negedge clock);
      checkOutput("zero data", 256'(lhs_data), 256'(0));
      checkOutput("zero ptr", 256'(lhs_ptr), 256'(0));
      checkOutput("zero nnz", 256'(nnz_total), 256'(0));
      checkOutput("zero start", 256'(lhs_start), 256'(1));
      checkOutput("zero last", 256'(lhs_last), 256'(1));
      @(posedge clock);
      #1;
      drainFrame(100, -1, 0, 1'b0);

      // Row 0 cols 0-4 = 10+c, row 1 cols 0-13 = 30+c, rest zero.
      for (int r = 0; r < N; r++) stimMat[r] = '0;
      for (int c = 0; c < 5; c++)  stimMat[0][c] = W'(10 + c);
      for (int c = 0; c < 14; c++) stimMat[1][c] = W'(30 + c);
      applyStimulus(0);
      @(negedge clock);
      checkOutput("split c0 data4", 256'(lhs_data[4]), 256'(14));
      checkOutput("split c0 data5", 256'(lhs_data[5]), 256'(30));
      checkOutput("split c0 data15", 256'(lhs_data[15]), 256'(40));
      checkOutput("split c0 col15", 256'(lhs_col[15]), 256'(10));
      checkOutput("split ptr0", 256'(lhs_ptr[0]), 256'(5));
      checkOutput("split ptr1", 256'(lhs_ptr[1]), 256'(19));
      checkOutput("split ptr15", 256'(lhs_ptr[15]), 256'(19));
      checkOutput("split c0 last", 256'(lhs_last), 256'(0));
      @(posedge clock);
      #1;
      lhs_ready = 1'b1;
      @(posedge clock);
      #1;
      lhs_ready = 1'b0;
      @(negedge clock);
      checkOutput("split c1 data0", 256'(lhs_data[0]), 256'(41));
      checkOutput("split c1 col0", 256'(lhs_col[0]), 256'(11));
      checkOutput("split c1 col2", 256'(lhs_col[2]), 256'(13));
      checkOutput("split c1 data3", 256'(lhs_data[3]), 256'(0));
      checkOutput("split c1 start", 256'(lhs_start), 256'(0));
      checkOutput("split c1 last", 256'(lhs_last), 256'(1));
      @(posedge clock);
      #1;
      drainFrame(100, -1, 0, 1'b0);

      // All ones, with a 3-cycle stall while chunk 1 is presented.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) stimMat[r][c] = 8'd1;
      applyStimulus(0);
      @(negedge clock);
      checkOutput("ones ptr0", 256'(lhs_ptr[0]), 256'(16));
      checkOutput("ones ptr14", 256'(lhs_ptr[14]), 256'(240));
      checkOutput("ones ptr15", 256'(lhs_ptr[15]), 256'(0));
      checkOutput("ones nnz", 256'(nnz_total), 256'(256));
      checkOutput("ones wrap", 256'(ptr_wrap), 256'(1));
      checkOutput("ones col9", 256'(lhs_col[9]), 256'(9));
      checkOutput("ones last", 256'(lhs_last), 256'(0));
      @(posedge clock);
      #1;
      drainFrame(100, 1, 3, 1'b0);

      // All ones again, reset hits while chunk 3 is presented.
      applyStimulus(0);
      for (int k = 0; k < 3; k++) begin
         lhs_ready = 1'b1;
         @(posedge clock);
         #1;
      end
      lhs_ready = 1'b0;
      checkOutput("pre-reset valid", 256'(lhs_valid), 256'(1));
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async valid", 256'(lhs_valid), 256'(0));
      checkOutput("async start", 256'(lhs_start), 256'(0));
      checkOutput("async data", 256'(lhs_data), 256'(0));
      checkOutput("async col", 256'(lhs_col), 256'(0));
      checkOutput("async ptr", 256'(lhs_ptr), 256'(0));
      checkOutput("async nnz", 256'(nnz_total), 256'(0));
      checkOutput("async wrap", 256'(ptr_wrap), 256'(0));
      checkOutput("async row_ready", 256'(row_ready), 256'(0));
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("post-reset row_ready", 256'(row_ready), 256'(1));
      randomMatrix(60);
      applyStimulus(10);
      drainFrame(100, -1, 0, 1'b0);

      // Random frames of varying density, gaps, readiness and junk rows.
      for (int f = 0; f < 10; f++) begin
         randomMatrix(int'($urandom_range(100)));
         applyStimulus(int'($urandom_range(40)));
         drainFrame(30 + int'($urandom_range(70)), -1, 0, 1'b1);
      end

      @(posedge clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
